// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch sequencing controller.
// Holds the one-hot mode encoding and the BCD digit limits.
package stopwatch_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'b100,
      RUNNING = 3'b001,
      CLEAR   = 3'b010
   } state_t;

   localparam logic [3:0] DIGIT_MAX = 4'd9;
   localparam logic [7:0] CS_MAX    = 8'h99;
   localparam logic [7:0] SEC_MAX   = 8'h59;

   function automatic logic [7:0] to_bcd(input int unsigned n);
      logic [3:0] hi;
      logic [3:0] lo;
      hi = 4'(n / 10);
      lo = 4'(n % 10);
      return {hi, lo};
   endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button inputs and time/status outputs of the stopwatch controller.
// master drives the buttons, slave is the controller itself.
interface stopwatch_ctrl_if;
   import stopwatch_pkg::*;

   logic       pb_run;
   logic       pb_clear;
   logic       pb_idle;
   logic       pb_lap;
   state_t     mode;
   logic [7:0] cs_bcd;
   logic [7:0] sec_bcd;
   logic [7:0] min_bcd;
   logic       running;
   logic       wrap;

   modport master (
      output pb_run, pb_clear, pb_idle, pb_lap,
      input  mode, cs_bcd, sec_bcd, min_bcd,
      input  running, wrap
   );

   modport slave (
      input  pb_run, pb_clear, pb_idle, pb_lap,
      output mode, cs_bcd, sec_bcd, min_bcd,
      output running, wrap
   );

endinterface

// File: rtl/bcd_digit_pair.sv
// Two-digit BCD counter wrapping at a BCD limit.
// carry is high in the cycle the pair steps from max back to 00.
module bcd_digit_pair
   import stopwatch_pkg::*;
(
   input  logic       hz100,
   input  logic       reset,
   input  logic       en,
   input  logic       clr,
   input  logic [7:0] max,
   output logic [7:0] value,
   output logic       carry
);

   logic       at_max;
   logic [7:0] inc;

   assign at_max = (value == max);
   assign carry  = en & at_max;

   // BCD increment: low digit rolls 9 -> 0 into the high digit
   always_comb begin
      inc = value;
      if (value[3:0] == DIGIT_MAX) begin
         inc = {value[7:4] + 4'd1, 4'd0};
      end else begin
         inc[3:0] = value[3:0] + 4'd1;
      end
   end

   // Count register; clear beats enable
   always_ff @(posedge hz100) begin
      if (reset || clr) begin
         value <= 8'h00;
      end else if (en) begin
         value <= at_max ? 8'h00 : inc;
      end
   end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch mode FSM, button edge detect and MM:SS.CC BCD counter.
// Optional lap snapshot is built when STOPWATCH_LAP_EN is defined.
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int unsigned TICK_DIV = 1,
   parameter int unsigned MAX_MIN  = 59
) (
   input  logic        hz100,
   input  logic        reset,
   stopwatch_ctrl_if.slave sw
);

   localparam logic [7:0] MIN_MAX  = to_bcd(MAX_MIN);
   localparam logic [7:0] DIV_LAST = 8'(TICK_DIV - 1);

   state_t     state;
   state_t     nxt;
   logic       prev_run;
   logic       prev_clear;
   logic       prev_idle;
   logic       ev_run;
   logic       ev_clear;
   logic       ev_idle;
   logic       single;
   logic [7:0] presc;
   logic       tick;
   logic       clr;
   logic [7:0] cs_live;
   logic [7:0] sec_live;
   logic [7:0] min_live;
   logic       c_cs;
   logic       c_sec;
   logic       c_min;
   logic       wrap_q;

   assign ev_run   = sw.pb_run & ~prev_run;
   assign ev_clear = sw.pb_clear & ~prev_clear;
   assign ev_idle  = sw.pb_idle & ~prev_idle;
   assign single   = $onehot({ev_run, ev_clear, ev_idle});

   // Button history for rising-edge detection
   always_ff @(posedge hz100) begin
      if (reset) begin
         prev_run   <= 1'b0;
         prev_clear <= 1'b0;
         prev_idle  <= 1'b0;
      end else begin
         prev_run   <= sw.pb_run;
         prev_clear <= sw.pb_clear;
         prev_idle  <= sw.pb_idle;
      end
   end

   // Mode register
   always_ff @(posedge hz100) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= nxt;
      end
   end

   // Next mode; simultaneous edges are ignored as a whole
   always_comb begin
      nxt = state;
      case (state)
         IDLE: begin
            if (single && ev_run) nxt = RUNNING;
         end
         RUNNING: begin
            if (single && ev_clear) nxt = CLEAR;
            else if (single && ev_idle) nxt = IDLE;
         end
         CLEAR: begin
            if (single && ev_idle) nxt = IDLE;
            else if (single && ev_run) nxt = RUNNING;
         end
         default: nxt = IDLE;
      endcase
   end

   assign tick = (state == RUNNING) && (presc == DIV_LAST);

   // Centisecond prescaler, held at zero outside RUNNING
   always_ff @(posedge hz100) begin
      if (reset || state != RUNNING || tick) begin
         presc <= 8'd0;
      end else begin
         presc <= presc + 8'd1;
      end
   end

   assign clr = (nxt == CLEAR);

   bcd_digit_pair u_cs (
      .hz100 (hz100),
      .reset (reset),
      .en    (tick),
      .clr   (clr),
      .max   (CS_MAX),
      .value (cs_live),
      .carry (c_cs)
   );

   bcd_digit_pair u_sec (
      .hz100 (hz100),
      .reset (reset),
      .en    (c_cs),
      .clr   (clr),
      .max   (SEC_MAX),
      .value (sec_live),
      .carry (c_sec)
   );

   bcd_digit_pair u_min (
      .hz100 (hz100),
      .reset (reset),
      .en    (c_sec),
      .clr   (clr),
      .max   (MIN_MAX),
      .value (min_live),
      .carry (c_min)
   );

   // Wrap pulse follows the full-range rollover
   always_ff @(posedge hz100) begin
      if (reset) begin
         wrap_q <= 1'b0;
      end else begin
         wrap_q <= c_min & ~clr;
      end
   end

   assign sw.mode    = state;
   assign sw.running = (state == RUNNING);
   assign sw.wrap    = wrap_q;

`ifdef STOPWATCH_LAP_EN
   logic        prev_lap;
   logic        ev_lap;
   logic        lap_hold;
   logic [23:0] snap;

   assign ev_lap = sw.pb_lap & ~prev_lap;

   // Lap toggle and snapshot; dropped whenever RUNNING is left
   always_ff @(posedge hz100) begin
      if (reset) begin
         prev_lap <= 1'b0;
         lap_hold <= 1'b0;
         snap     <= 24'h0;
      end else begin
         prev_lap <= sw.pb_lap;
         if (nxt != RUNNING) begin
            lap_hold <= 1'b0;
         end else if (ev_lap && state == RUNNING) begin
            lap_hold <= ~lap_hold;
            snap     <= {min_live, sec_live, cs_live};
         end
      end
   end

   assign {sw.min_bcd, sw.sec_bcd, sw.cs_bcd} =
      lap_hold ? snap : {min_live, sec_live, cs_live};
`else
   logic unused_lap;
   assign unused_lap = sw.pb_lap;
   assign sw.min_bcd = min_live;
   assign sw.sec_bcd = sec_live;
   assign sw.cs_bcd  = cs_live;
`endif

endmodule
